// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for the single data-DRAM port: m0 (I-cache reads) and m1 (D-cache reads/writebacks).
// One transaction in flight at a time; the reply is routed back to its owner, with a timeout error path.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_r_request_valid,
  output logic                  m0_r_request_ready,
  input  logic [ADDR_WIDTH-1:0] m0_raddr,
  output logic                  m0_r_reply_valid,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic [1:0]            m0_rresp,
  input  logic                  m1_r_request_valid,
  output logic                  m1_r_request_ready,
  input  logic [ADDR_WIDTH-1:0] m1_raddr,
  output logic                  m1_r_reply_valid,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic [1:0]            m1_rresp,
  input  logic                  m1_w_request_valid,
  output logic                  m1_w_request_ready,
  input  logic [ADDR_WIDTH-1:0] m1_waddr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_w_reply_valid,
  output logic [1:0]            m1_bresp,
  output logic                  s_r_request_valid,
  input  logic                  s_r_request_ready,
  output logic [ADDR_WIDTH-1:0] s_raddr,
  input  logic                  s_r_reply_valid,
  input  logic [DATA_WIDTH-1:0] s_rdata,
  output logic                  s_w_request_valid,
  input  logic                  s_w_request_ready,
  output logic [ADDR_WIDTH-1:0] s_waddr,
  output logic [DATA_WIDTH-1:0] s_wdata,
  input  logic                  s_w_reply_valid
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;
  typedef enum logic [1:0] {SRC_M0R, SRC_M1W, SRC_M1R} src_t;

  state_t                state_q, state_d;
  src_t                  owner_q, owner_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  last_master_q, last_master_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic       m0_req, m1_req, any_req, pick_m0;
  src_t       gnt_src;
  logic       is_wr, rsp_ok, rsp_to, done;
  logic [1:0] resp;

  // Grant: round-robin between masters, writeback ahead of refill inside m1.
  always_comb begin
    m0_req  = m0_r_request_valid;
    m1_req  = m1_w_request_valid | m1_r_request_valid;
    any_req = m0_req | m1_req;
    pick_m0 = m0_req && (!m1_req || last_master_q);
    gnt_src = pick_m0 ? SRC_M0R : (m1_w_request_valid ? SRC_M1W : SRC_M1R);

    m0_r_request_ready = (state_q == ST_IDLE) && any_req && (gnt_src == SRC_M0R);
    m1_w_request_ready = (state_q == ST_IDLE) && any_req && (gnt_src == SRC_M1W);
    m1_r_request_ready = (state_q == ST_IDLE) && any_req && (gnt_src == SRC_M1R);
  end

  always_comb begin
    is_wr  = (owner_q == SRC_M1W);
    rsp_ok = (state_q == ST_WAIT) && (is_wr ? s_w_reply_valid : s_r_reply_valid);
    rsp_to = (state_q == ST_WAIT) && !rsp_ok && (cnt_q == CNT_W'(TIMEOUT));
    done   = rsp_ok | rsp_to;
    resp   = rsp_to ? 2'b10 : 2'b00;

    s_r_request_valid = (state_q == ST_ISSUE) && !is_wr;
    s_w_request_valid = (state_q == ST_ISSUE) && is_wr;
    s_raddr = raddr_q;
    s_waddr = waddr_q;
    s_wdata = wdata_q;

    m0_rdata = s_rdata;
    m1_rdata = s_rdata;
    m0_r_reply_valid = done && (owner_q == SRC_M0R);
    m1_r_reply_valid = done && (owner_q == SRC_M1R);
    m1_w_reply_valid = done && (owner_q == SRC_M1W);
    m0_rresp = m0_r_reply_valid ? resp : 2'b00;
    m1_rresp = m1_r_reply_valid ? resp : 2'b00;
    m1_bresp = m1_w_reply_valid ? resp : 2'b00;
  end

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    cnt_d         = cnt_q;
    last_master_d = last_master_q;
    raddr_d       = raddr_q;
    waddr_d       = waddr_q;
    wdata_d       = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          owner_d       = gnt_src;
          last_master_d = (gnt_src != SRC_M0R);
          state_d       = ST_ISSUE;
          case (gnt_src)
            SRC_M0R: raddr_d = m0_raddr;
            SRC_M1R: raddr_d = m1_raddr;
            default: begin
              waddr_d = m1_waddr;
              wdata_d = m1_wdata;
            end
          endcase
        end
      end
      ST_ISSUE: begin
        if (is_wr ? s_w_request_ready : s_r_request_ready) begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (done) state_d = ST_IDLE;
        else      cnt_d   = cnt_q + CNT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      owner_q       <= SRC_M0R;
      cnt_q         <= '0;
      last_master_q <= 1'b1;
      raddr_q       <= '0;
      waddr_q       <= '0;
      wdata_q       <= '0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      cnt_q         <= cnt_d;
      last_master_q <= last_master_d;
      raddr_q       <= raddr_d;
      waddr_q       <= waddr_d;
      wdata_q       <= wdata_d;
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

- Shares the single 128-bit data-DRAM port between two cache-side requesters: m0 (I-cache refill, read only) and m1 (D-cache, refill reads and writebacks).
- Sits between the L1 caches and the data DRAM; keeps exactly one transaction outstanding and routes the reply back to the requester that issued it.
- Guards against a lost reply with a per-transaction timeout that returns an error response.

## Interface
- ADDR_WIDTH, 32, request address width
- DATA_WIDTH, 128, block width (one cache line per transfer)
- TIMEOUT, 64, max cycles in WAIT before error completion (≥ 4)
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- m0_r_request_valid  in  1  m0 read request
- m0_r_request_ready  out  1  m0 read accepted this cycle
- m0_raddr  in  ADDR_WIDTH  m0 read address
- m0_r_reply_valid  out  1  one-cycle reply pulse to m0
- m0_rdata  out  DATA_WIDTH  read data (= s_rdata)
- m0_rresp  out  2  00 OK, 10 timeout
- m1_r_request_valid  in  1  m1 read request
- m1_r_request_ready  out  1  m1 read accepted this cycle
- m1_raddr  in  ADDR_WIDTH  m1 read address
- m1_r_reply_valid  out  1  one-cycle read reply pulse to m1
- m1_rdata  out  DATA_WIDTH  read data (= s_rdata)
- m1_rresp  out  2  00 OK, 10 timeout
- m1_w_request_valid  in  1  m1 write request
- m1_w_request_ready  out  1  m1 write accepted this cycle
- m1_waddr  in  ADDR_WIDTH  m1 write address
- m1_wdata  in  DATA_WIDTH  m1 write block
- m1_w_reply_valid  out  1  one-cycle write completion pulse
- m1_bresp  out  2  00 OK, 10 timeout
- s_r_request_valid  out  1  read request to DRAM
- s_r_request_ready  in  1  DRAM accepts read
- s_raddr  out  ADDR_WIDTH  latched read address
- s_r_reply_valid  in  1  DRAM read reply pulse
- s_rdata  in  DATA_WIDTH  DRAM read data
- s_w_request_valid  out  1  write request to DRAM
- s_w_request_ready  in  1  DRAM accepts write
- s_waddr  out  ADDR_WIDTH  latched write address
- s_wdata  out  DATA_WIDTH  latched write data
- s_w_reply_valid  in  1  DRAM write completion pulse

## Operation
- **Sources:** three request sources — S0 = m0 read, S1 = m1 write, S2 = m1 read.
- **Grant (IDLE only, combinational):**
  - Between masters: round-robin on `last_master`. Reset value is 1, so m0 wins first.
  - Within m1: write beats read, so a writeback precedes the refill of the same line.
  - Exactly one `*_request_ready` is high, only in IDLE, and only for the granted source.
  - Handshake = valid & ready.
  - On handshake: latch address, wdata and op (rd/wr); record the owner; update `last_master`; go to ISSUE.
- **ISSUE:**
  - Drive `s_r_request_valid` or `s_w_request_valid` from the latched registers.
  - Hold until the matching `s_*_request_ready` is seen; then clear the timeout counter and go to WAIT.
  - Not timed out.
- **WAIT:**
  - On the matching `s_*_reply_valid`, pulse the owner's `*_reply_valid` in the same cycle with resp 00, then go to IDLE.
  - The counter increments each WAIT cycle. When it reaches TIMEOUT with no reply: pulse the owner's reply with resp 10 (rdata don't-care), then go to IDLE.
- **Stray replies:** `s_*_reply_valid` outside WAIT, or of the wrong op type, is discarded; no master output toggles.
- **No backpressure on replies:** masters must consume reply pulses.
- **Data path:** `m0_rdata` and `m1_rdata` are combinational copies of `s_rdata`.
- **Registered outputs:** `s_raddr`, `s_waddr`, `s_wdata` hold their last latched value and change only on a master handshake.

## Timing
- **Reset (rst=1 at posedge), mid-transaction included:**
  - state = IDLE, counter = 0, `last_master` = 1.
  - All `s_*_valid` and all master `*_reply_valid` are 0; all resp outputs are 00; address/data registers are 0.
  - An in-flight DRAM reply arriving after reset is discarded.
- **Latency:**
  - Handshake at cycle T; s request valid at T+1.
  - With a DRAM that accepts immediately and replies 2 cycles after acceptance, the master reply arrives at T+3.
  - Next grant is possible at T+4, giving one transaction per 4 cycles at best.
- **Timeout:** the error pulse occurs exactly TIMEOUT cycles after entering WAIT.
- **Simultaneous requests:** all three sources valid in one cycle → grant follows the round-robin rule; losers stay un-readied and must hold valid.

## Test plan
- **Lone m0 read:** m0 read 0x40 alone → `m0_r_request_ready` at T, `s_r_request_valid` with `s_raddr`=0x40 at T+1, `m0_r_reply_valid`=1 with rdata=DRAM[0x40] and rresp=00 at T+3, m1 outputs stay 0.
- **Round-robin fairness:** m0 and m1 reads held continuously from reset → grants m0, m1, m0, m1, each 4 cycles apart.
- **Write before read:** m1 write 0x80 (wdata 0xA5…A5) and m1 read 0x80 asserted together → write granted first, `m1_w_reply_valid` pulse; then read returns 0xA5…A5.
- **Timeout:** DRAM reply suppressed, TIMEOUT=8 → `m1_rresp`=10 with reply pulse exactly 8 cycles after WAIT entry; state returns to IDLE. A late `s_r_reply_valid` then produces no master pulse.
- **Reset mid-transaction:** rst asserted during WAIT → next cycle all outputs at reset values; m0 granted first afterwards.
- **DRAM backpressure:** `s_r_request_ready` held low for 5 cycles in ISSUE → `s_r_request_valid` and `s_raddr` stay stable; no timeout counting occurs.
